// File: rtl/instr_fetch_queue.sv
// Fetch-side PC owner and {pc, instr} FIFO feeding decode over valid/ready.
// Optional build macro IFQ_HOLE_SKIP_EN: zero or X/Z memory words are skipped, not enqueued.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd1999,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                imem_pc,
    input  logic [31:0]                imem_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       dec_valid,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       fetch_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    typedef enum logic { RUN, STOP } state_t;

    state_t           state;
    ifq_entry_t       fifo_q [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             hole, fetch, enq, deq;

`ifdef IFQ_HOLE_SKIP_EN
    assign hole = (imem_instr == 32'd0) || $isunknown(imem_instr);
`else
    assign hole = 1'b0;
`endif

    // A fetch slot consumes the PC; a hole consumes it without occupying an entry.
    assign fetch = (state == RUN) && (count != CW'(DEPTH)) && !redirect_valid;
    assign enq   = fetch && !hole;
    assign deq   = dec_valid && dec_ready && !redirect_valid;

    assign dec_valid = (count != '0);
    assign dec_pc    = dec_valid ? fifo_q[rptr].pc    : 32'd0;
    assign dec_instr = dec_valid ? fifo_q[rptr].instr : 32'd0;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (enq)
            fifo_q[wptr] <= '{pc: imem_pc, instr: imem_instr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_pc    <= RESET_PC;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            state      <= RUN;
            fetch_done <= 1'b0;
        end else if (redirect_valid) begin
            imem_pc    <= redirect_pc;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            state      <= (redirect_pc > PC_LIMIT) ? STOP : RUN;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= (state == STOP) && (count == '0);
            if (fetch) begin
                if (imem_pc == PC_LIMIT)
                    state <= STOP;
                else
                    imem_pc <= imem_pc + 32'd1;
            end
            if (enq)
                wptr <= wptr + 1'b1;
            if (deq)
                rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue against a queue-based fetch model.
module tb_instr_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] PC_LIMIT = 32'd100;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc, imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        dec_valid, dec_ready = 1'b0, fetch_done;
    logic [31:0] dec_instr, dec_pc;
    logic [$clog2(DEPTH):0] occupancy;

    logic [31:0] mem [256];
    assign imem_instr = mem[imem_pc[7:0]];

    instr_fetch_queue #(.RESET_PC(RESET_PC), .PC_LIMIT(PC_LIMIT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .occupancy(occupancy), .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q [$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_stopped = 0, m_done = 0, pop_pending = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_hole(input logic [31:0] w);
`ifdef IFQ_HOLE_SKIP_EN
        return (w == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc = RESET_PC; m_stopped = 0; m_done = 0; pop_pending = 0;
    endtask

    // Reference model: advances one fetch step per clock using the spec's rules.
    always @(posedge clk) begin
        if (rst_n) begin
            int  occ;
            bit  done_next;
            occ = exp_q.size() + int'(pop_pending);
            pop_pending = 0;
            done_next = redirect_valid ? 1'b0 : (m_stopped && occ == 0);
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = redirect_pc;
                m_stopped = (redirect_pc > PC_LIMIT);
            end else if (!m_stopped && occ < DEPTH) begin
                if (!is_hole(mem[m_pc[7:0]]))
                    exp_q.push_back('{pc: m_pc, instr: mem[m_pc[7:0]]});
                if (m_pc == PC_LIMIT) m_stopped = 1;
                else                  m_pc = m_pc + 1;
            end
            m_done = done_next;
        end
    end

    // Monitor: compares DUT state against the model and retires accepted heads.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("imem_pc", imem_pc, m_pc);
            chk("fetch_done", 32'(fetch_done), 32'(m_done));
            chk("dec_valid", 32'(dec_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("dec_pc", dec_pc, exp_q[0].pc);
                chk("dec_instr", dec_instr, exp_q[0].instr);
                if (dec_ready && !redirect_valid) begin
                    void'(exp_q.pop_front());
                    pop_pending = 1;
                end
            end else begin
                chk("dec_pc_empty", dec_pc, 32'd0);
                chk("dec_instr_empty", dec_instr, 32'd0);
            end
        end
    end

    task automatic cyc(input bit rdy, input bit redir, input logic [31:0] rpc);
        @(posedge clk); #1;
        dec_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_pc"}, imem_pc, RESET_PC);
        chk({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
        chk({tag, "_dec_pc"}, dec_pc, 32'd0);
        chk({tag, "_dec_instr"}, dec_instr, 32'd0);
        chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        chk({tag, "_fetch_done"}, 32'(fetch_done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom | 32'h1);
        mem[0] = 32'h8E110000; mem[1] = 32'd0; mem[2] = 32'd0; mem[3] = 32'h00C0FFEE;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        dec_ready = 1'b1;

        // Streaming with decode always ready, then a 10-cycle stall and drain.
        repeat (6)  cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 0);
        repeat (8)  cyc(1, 0, 0);

        // Redirect with entries queued.
        repeat (4) cyc(0, 0, 0);
        cyc(0, 1, 32'd87);
        repeat (4) cyc(1, 0, 0);

        // Random traffic, including redirects beyond the limit.
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 110));

        // Run into PC_LIMIT and drain; fetch_done must rise, redirect clears it.
        cyc(1, 1, 32'd90);
        repeat (30) cyc(1, 0, 0);
        @(negedge clk);
        chk("limit_done", 32'(fetch_done), 32'd1);
        chk("limit_pc", imem_pc, PC_LIMIT);
        cyc(1, 1, 32'd0);
        repeat (6) cyc(1, 0, 0);

        // Asynchronous reset between edges with the queue full.
        repeat (8) cyc(0, 0, 0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 40; i++)
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, $urandom_range(0, 110));
        cyc(1, 0, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
